// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with round-robin auto-scan.
//
// Manual mode forwards the selected channel one cycle later. Scan mode steps
// through the channels enabled in ch_mask and holds each one for DWELL cycles.
// It pulses wrap on the first valid sample of every pass that begins after a
// wrap-around.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   din      flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   sel      manual channel select
//   mode     0 = manual, 1 = scan
//   en       clock enable for all state
//   ch_mask  per-channel enable, 1 = channel enabled
//   dout     registered selected data
//   out_ch   channel index that dout was taken from
//   valid    dout holds data from an enabled channel
//   wrap     one-cycle pulse on the first sample of a new scan pass
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS*WIDTH-1:0]     din,
  input  logic [$clog2(CHANNELS)-1:0]   sel,
  input  logic                          mode,
  input  logic                          en,
  input  logic [CHANNELS-1:0]           ch_mask,
  output logic [WIDTH-1:0]              dout,
  output logic [$clog2(CHANNELS)-1:0]   out_ch,
  output logic                          valid,
  output logic                          wrap
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0] ch_data [CHANNELS];

  logic [WIDTH-1:0] dout_q,   dout_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             valid_q,  valid_d;
  logic             wrap_q,   wrap_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  // Set by an advance whose new index is not above the old one. The next
  // valid sample is then the start of a fresh pass and carries the wrap pulse.
  logic             pend_q,   pend_d;

  logic [SEL_W-1:0] next_ch;
  logic [SEL_W-1:0] cand;
  logic             found;
  logic             next_wraps;
  logic             sel_ok;
  logic             advance;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ch_data[k] = din[k*WIDTH +: WIDTH];
    end
  end

  // Next enabled channel strictly after cur_ch, searched modulo CHANNELS. If
  // cur_ch is the only enabled channel, the search lands back on cur_ch.
  always_comb begin
    next_ch = cur_ch_q;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = SEL_W'((int'(cur_ch_q) + k) % CHANNELS);
      if (!found && ch_mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  assign next_wraps = (next_ch <= cur_ch_q);
  assign sel_ok     = (int'(sel) < CHANNELS);
  // A channel masked off under the scan is left at once, without waiting for
  // its dwell to run out.
  assign advance    = !ch_mask[cur_ch_q] || (cnt_q == CNT_W'(DWELL - 1));

  // NOTE: every output of this block is given a default first, so no path
  // through it leaves a variable unassigned and no latch is inferred.
  always_comb begin
    dout_d   = dout_q;
    out_ch_d = out_ch_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;

    if (en) begin
      if (!mode) begin
        out_ch_d = sel;
        cnt_d    = '0;
        pend_d   = 1'b0;
        if (sel_ok) begin
          dout_d   = ch_data[sel];
          valid_d  = ch_mask[sel];
          cur_ch_d = sel;
        end else begin
          // An out-of-range select gives zero data and never moves cur_ch
          // past the last real channel.
          dout_d   = '0;
          cur_ch_d = '0;
        end
      end else if (ch_mask == '0) begin
        cnt_d = '0;
      end else begin
        dout_d   = ch_data[cur_ch_q];
        out_ch_d = cur_ch_q;
        valid_d  = ch_mask[cur_ch_q];
        wrap_d   = pend_q & ch_mask[cur_ch_q];
        if (ch_mask[cur_ch_q]) begin
          pend_d = 1'b0;
        end
        if (advance) begin
          cur_ch_d = next_ch;
          cnt_d    = '0;
          if (next_wraps) begin
            pend_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, whatever order they are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      cur_ch_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      out_ch_q <= out_ch_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign dout   = dout_q;
  assign out_ch = out_ch_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised, registered N-channel W-bit multiplexer. It generalises the combinational 2:1 and 4:1 muxes to any channel count and width, and adds two things: a registered output with a valid flag, and an auto-scan mode. In scan mode the block steps round-robin through the channels enabled in a mask, holding each for a fixed dwell time. It sits between parallel data sources and a single shared sink, for example a display or a serial reporter.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (≥2).
- DWELL, 4, clock cycles spent on each channel in scan mode (≥1).
- SEL_W, derived localparam = clog2(CHANNELS), select width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  clock enable for all state.
- ch_mask  input  CHANNELS  1 = channel enabled.
- dout  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  channel index that dout was taken from.
- valid  output  1  dout holds data from an enabled channel.
- wrap  output  1  one-cycle pulse marking the first sample of a new scan pass.

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n=0 immediately forces dout=0, out_ch=0, valid=0, wrap=0, internal cur_ch=0, dwell counter cnt=0.
- Reset is honoured mid-dwell and mid-pass. After release, scanning restarts at channel 0 with cnt=0.
- All updates occur on the rising clk edge when en=1.
- en=0: every register holds, except valid and wrap, which are cleared. The dwell count resumes where it left off when en returns to 1.
- Manual mode (mode=0), one-cycle latency:
  - dout<=din[sel], out_ch<=sel, valid<=ch_mask[sel], wrap<=0, cnt<=0, cur_ch<=sel.
  - A masked channel is still forwarded, but with valid=0.
- Scan mode (mode=1), evaluated each enabled cycle:
  - dout<=din[cur_ch], out_ch<=cur_ch, valid<=ch_mask[cur_ch].
  - If ch_mask==0: valid<=0, dout and out_ch hold, cnt<=0, cur_ch holds.
  - Else if ch_mask[cur_ch]==0 (mask changed under the scan): advance immediately, without waiting for cnt.
  - Else if cnt==DWELL-1: advance and set cnt<=0.
  - Else: cnt<=cnt+1.
- Advance: cur_ch<=the next enabled index above cur_ch, wrapping modulo CHANNELS to the lowest enabled index. If only one channel is enabled, the scan advances to itself.
- wrap:
  - Asserted for exactly one cycle, coincident with the first valid dout of a pass taken after a wrap-around, i.e. after an advance where new index ≤ old index.
  - A single enabled channel therefore pulses wrap once every DWELL cycles.
  - The first pass after reset or after a mode change does not pulse wrap.
- Mode change 0→1: the scan starts from the current cur_ch (last sel) with cnt=0. Mode change 1→0: manual behaviour applies on the next edge.
- DWELL=1: the scan advances every enabled cycle.
- CHANNELS that are not a power of two: cur_ch never exceeds CHANNELS-1; an out-of-range manual sel yields dout=0, valid=0.

Test Plan:
Common setup: WIDTH=4, CHANNELS=4, DWELL=4, din channels 0..3 = A, B, C, D.
1. Assert rst_n=0 mid-dwell in scan mode → dout, out_ch, valid and wrap go to 0 immediately, with no clock edge. After release, out_ch sequence is 0,0,0,0,1…
2. Manual, sel=2, mask=1111 → one edge later dout=C, out_ch=2, valid=1. Set mask=1011 → valid=0, dout=C.
3. Scan, mask=1111, for 20 cycles → dout sequence is A×4, B×4, C×4, D×4, A×4. wrap=1 only on the first A of the second pass.
4. Scan, mask=1010 → dout sequence is B×4, D×4, B×4, with wrap on the first B of the repeat. Clear bit 3 while on D → advance to B on the next edge.
5. Scan, mask=0000 → valid=0 and dout holds its last value. Restoring mask=0001 → A repeats, with wrap every 4 cycles.
6. en=0 for 3 cycles after the second A → dout and out_ch hold, valid=0. Resuming gives two more A samples before B.
